// File: rtl/jstk_position_filter.sv
// rtl/jstk_position_filter.sv - PmodJSTK frame decode, centre calibration, deadzone and velocity scaling
//
// Decodes raw 40-bit joystick frames into X/Y positions and buttons, then
// converts position into a saturated signed velocity about a calibrated centre.
// Two-stage pipeline: frame_valid in cycle N gives out_valid in cycle N+2.
//
// Optional feature macro: BTN_FILTER_EN (button debounce over 2 frames).
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   frame_valid/data      raw frame strobe and 40-bit payload
//   cal_req               pulse to start centre calibration
//   pos_x/pos_y/btn       decoded raw position and buttons
//   vel_x/vel_y           signed velocity, -127..+127
//   out_valid             pulse when outputs update
//   cal_busy              calibration in progress
//   center_x/center_y     current centre
module jstk_position_filter #(
  parameter int CAL_LOG2 = 3,
  parameter int DEADZONE = 16,
  parameter int SHIFT    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        frame_valid,
  input  logic [39:0] frame_data,
  input  logic        cal_req,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic [1:0]  btn,
  output logic [7:0]  vel_x,
  output logic [7:0]  vel_y,
  output logic        out_valid,
  output logic        cal_busy,
  output logic [9:0]  center_x,
  output logic [9:0]  center_y
);

  localparam int ACC_W = 10 + CAL_LOG2;
  localparam logic signed [10:0] DZ = 11'(DEADZONE);

  typedef enum logic [1:0] {IDLE, ACC, UPD} state_t;

  state_t state_q, state_d;

  logic [9:0]          in_x, in_y;
  logic [1:0]          in_btn, btn_sel;
  logic                unused_bits;

  logic [ACC_W-1:0]    acc_x, acc_y;
  logic [CAL_LOG2-1:0] cnt;

  logic                s1_valid, s1_zero;
  logic [9:0]          s1_x, s1_y;
  logic [1:0]          s1_btn;
  logic signed [10:0]  s1_dx, s1_dy;

  assign in_x        = {frame_data[25:24], frame_data[39:32]};
  assign in_y        = {frame_data[9:8], frame_data[23:16]};
  assign in_btn      = frame_data[1:0];
  assign unused_bits = ^{frame_data[31:26], frame_data[15:10], frame_data[7:2]};

  assign cal_busy = (state_q != IDLE);

`ifdef BTN_FILTER_EN
  // A button value is accepted only once two consecutive frames agree.
  logic [1:0] btn_cand, btn_held;

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_cand <= '0;
      btn_held <= '0;
    end else if (frame_valid) begin
      btn_cand <= in_btn;
      if (in_btn == btn_cand) btn_held <= in_btn;
    end
  end

  assign btn_sel = (in_btn == btn_cand) ? in_btn : btn_held;
`else
  assign btn_sel = in_btn;
`endif

  // Deadzone removal, arithmetic scaling, then symmetric saturation so -128 never appears.
  function automatic logic signed [7:0] shape(input logic signed [10:0] d);
    logic signed [10:0] dz, sh;
    if (d > DZ)       dz = d - DZ;
    else if (d < -DZ) dz = d + DZ;
    else              dz = '0;
    sh = dz >>> SHIFT;
    if (sh > 11'sd127)       return 8'sd127;
    else if (sh < -11'sd127) return -8'sd127;
    else                     return sh[7:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cal_req) state_d = ACC;
      ACC:     if (frame_valid && cnt == '1) state_d = UPD;
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Samples are taken straight from the incoming frame; these equal the stage-1 values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_x    <= '0;
      acc_y    <= '0;
      cnt      <= '0;
      center_x <= 10'd512;
      center_y <= 10'd512;
    end else begin
      case (state_q)
        IDLE: if (cal_req) begin
          acc_x <= '0;
          acc_y <= '0;
          cnt   <= '0;
        end
        ACC: if (frame_valid) begin
          acc_x <= acc_x + ACC_W'(in_x);
          acc_y <= acc_y + ACC_W'(in_y);
          cnt   <= cnt + CAL_LOG2'(1);
        end
        UPD: begin
          center_x <= acc_x[ACC_W-1:CAL_LOG2];
          center_y <= acc_y[ACC_W-1:CAL_LOG2];
        end
        default: ;
      endcase
    end
  end

  // Stage 1: capture fields and centre-relative offset; tag frames seen during calibration.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_btn   <= '0;
      s1_dx    <= '0;
      s1_dy    <= '0;
    end else begin
      s1_valid <= frame_valid;
      if (frame_valid) begin
        s1_zero <= (state_q != IDLE);
        s1_x    <= in_x;
        s1_y    <= in_y;
        s1_btn  <= btn_sel;
        s1_dx   <= $signed({1'b0, in_x}) - $signed({1'b0, center_x});
        s1_dy   <= $signed({1'b0, in_y}) - $signed({1'b0, center_y});
      end
    end
  end

  // Stage 2: velocity shaping; positions re-timed to align with velocity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      pos_x     <= '0;
      pos_y     <= '0;
      btn       <= '0;
      vel_x     <= '0;
      vel_y     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        pos_x <= s1_x;
        pos_y <= s1_y;
        btn   <= s1_btn;
        vel_x <= s1_zero ? 8'd0 : shape(s1_dx);
        vel_y <= s1_zero ? 8'd0 : shape(s1_dy);
      end
    end
  end

endmodule

// File: tb/tb_jstk_position_filter.sv
// tb/tb_jstk_position_filter.sv - directed self-checking bench for jstk_position_filter
module tb_jstk_position_filter;

  logic        CLK;
  logic        RST;
  logic        frame_valid;
  logic [39:0] frame_data;
  logic        cal_req;
  logic [9:0]  pos_x, pos_y;
  logic [1:0]  btn;
  logic [7:0]  vel_x, vel_y;
  logic        out_valid;
  logic        cal_busy;
  logic [9:0]  center_x, center_y;

  int checks   = 0;
  int failures = 0;

  jstk_position_filter dut (
    .CLK        (CLK),
    .RST        (RST),
    .frame_valid(frame_valid),
    .frame_data (frame_data),
    .cal_req    (cal_req),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .btn        (btn),
    .vel_x      (vel_x),
    .vel_y      (vel_y),
    .out_valid  (out_valid),
    .cal_busy   (cal_busy),
    .center_x   (center_x),
    .center_y   (center_y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Unused frame bits are set to 1 so a wrong field slice shows up.
  function automatic logic [39:0] mk(input int x, input int y, input int b);
    logic [9:0]  xv, yv;
    logic [1:0]  bv;
    logic [39:0] f;
    xv = x[9:0];
    yv = y[9:0];
    bv = b[1:0];
    f = '1;
    f[39:32] = xv[7:0];
    f[25:24] = xv[9:8];
    f[23:16] = yv[7:0];
    f[9:8]   = yv[9:8];
    f[1:0]   = bv;
    return f;
  endfunction

  task automatic drive_frame(input int x, input int y, input int b);
    frame_valid = 1'b1;
    frame_data  = mk(x, y, b);
    tick;
    frame_valid = 1'b0;
  endtask

  task automatic calibrate(input int x, input int y);
    cal_req = 1'b1;
    tick;
    cal_req = 1'b0;
    for (int i = 0; i < 8; i++) drive_frame(x, y, 0);
    tick;
    tick;
  endtask

  initial begin
    RST = 1'b1;
    frame_valid = 1'b0;
    frame_data = '0;
    cal_req = 1'b0;
    repeat (3) tick;

    chk("rst_pos_x", pos_x, 0);
    chk("rst_vel_x", $signed(vel_x), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cal_busy", cal_busy, 0);
    chk("rst_center_x", center_x, 512);
    chk("rst_center_y", center_y, 512);
    RST = 1'b0;
    tick;

    // Basic frame and latency
    drive_frame(700, 300, 1);
    chk("lat_n1_out_valid", out_valid, 0);
    tick;
    chk("f1_out_valid", out_valid, 1);
    chk("f1_pos_x", pos_x, 700);
    chk("f1_pos_y", pos_y, 300);
    chk("f1_btn", btn, 1);
    chk("f1_vel_x", $signed(vel_x), 43);
    chk("f1_vel_y", $signed(vel_y), -49);
    tick;
    chk("f1_pulse_end", out_valid, 0);

    // Deadzone edges
    drive_frame(520, 500, 0); tick;
    chk("dz_in_vel_x", $signed(vel_x), 0);
    chk("dz_in_vel_y", $signed(vel_y), 0);
    drive_frame(529, 500, 0); tick;
    chk("dz_17_vel_x", $signed(vel_x), 0);
    drive_frame(532, 500, 0); tick;
    chk("dz_20_vel_x", $signed(vel_x), 1);

    // Calibration 496..503, y=200
    cal_req = 1'b1;
    tick;
    cal_req = 1'b0;
    chk("cal_busy_start", cal_busy, 1);
    for (int i = 0; i < 8; i++) begin
      drive_frame(496 + i, 200, 0);
      if (i == 7) chk("cal_busy_upd", cal_busy, 1);
      tick;
      chk("cal_vel_x", $signed(vel_x), 0);
      chk("cal_vel_y", $signed(vel_y), 0);
      chk("cal_pos_x", pos_x, 496 + i);
      if (i < 7) chk("cal_busy_acc", cal_busy, 1);
    end
    chk("cal_busy_done", cal_busy, 0);
    chk("cal_center_x", center_x, 499);
    chk("cal_center_y", center_y, 200);
    drive_frame(499, 200, 0); tick;
    chk("post_cal_vel_x", $signed(vel_x), 0);
    chk("post_cal_vel_y", $signed(vel_y), 0);
    drive_frame(600, 200, 0); tick;
    chk("post_cal_600_vel_x", $signed(vel_x), 21);

    // Positive saturation
    calibrate(100, 512);
    chk("sat_center_x", center_x, 100);
    drive_frame(1023, 512, 0); tick;
    chk("sat_pos_vel_x", $signed(vel_x), 127);
    chk("sat_pos_vel_y", $signed(vel_y), 0);

    // Frame coincident with cal_req: processed normally, not accumulated
    cal_req = 1'b1;
    frame_valid = 1'b1;
    frame_data = mk(0, 512, 0);
    tick;
    cal_req = 1'b0;
    frame_valid = 1'b0;
    tick;
    chk("calreq_frame_vel_x", $signed(vel_x), -21);
    for (int i = 0; i < 8; i++) drive_frame(1000, 512, 0);
    tick;
    tick;
    chk("sat2_center_x", center_x, 1000);
    drive_frame(0, 512, 0); tick;
    chk("sat_neg_vel_x", $signed(vel_x), -127);

    // Reset mid-calibration
    cal_req = 1'b1;
    tick;
    cal_req = 1'b0;
    for (int i = 0; i < 4; i++) drive_frame(300, 300, 0);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    chk("midrst_cal_busy", cal_busy, 0);
    chk("midrst_center_x", center_x, 512);
    chk("midrst_center_y", center_y, 512);
    chk("midrst_out_valid", out_valid, 0);
    tick;
    chk("midrst_flushed", out_valid, 0);
    calibrate(600, 400);
    chk("recal_center_x", center_x, 600);
    chk("recal_center_y", center_y, 400);

    // Back-to-back frames, centre 600/400
    frame_valid = 1'b1;
    frame_data = mk(700, 300, 1);
    tick;
    frame_data = mk(532, 500, 2);
    tick;
    frame_data = mk(100, 900, 3);
    chk("b2b0_out_valid", out_valid, 1);
    chk("b2b0_pos_x", pos_x, 700);
    chk("b2b0_btn", btn, 1);
    chk("b2b0_vel_x", $signed(vel_x), 21);
    chk("b2b0_vel_y", $signed(vel_y), -21);
    tick;
    frame_valid = 1'b0;
    chk("b2b1_out_valid", out_valid, 1);
    chk("b2b1_pos_y", pos_y, 500);
    chk("b2b1_btn", btn, 2);
    chk("b2b1_vel_x", $signed(vel_x), -13);
    chk("b2b1_vel_y", $signed(vel_y), 21);
    tick;
    chk("b2b2_out_valid", out_valid, 1);
    chk("b2b2_pos_x", pos_x, 100);
    chk("b2b2_btn", btn, 3);
    chk("b2b2_vel_x", $signed(vel_x), -121);
    chk("b2b2_vel_y", $signed(vel_y), 121);
    tick;
    chk("b2b_end", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jstk_position_filter.md
Name: jstk_position_filter

Overview:
- Sits downstream of the PmodJSTK SPI interface and upstream of the display, LED and game-logic consumers.
- Takes each raw 40-bit joystick frame, extracts the X, Y and button fields, and applies a calibrated centre offset, a deadzone and scaling.
- Produces saturated signed velocities with a valid strobe.
- Contains a calibration state machine that averages 2^CAL_LOG2 frames to learn the stick centre.

Parameters:
- CAL_LOG2, 3, log2 of the number of frames averaged per calibration (8 frames).
- DEADZONE, 16, half-width of the deadzone around centre, in raw counts (0..255).
- SHIFT, 2, arithmetic right-shift applied after deadzone removal (0..7).

Ports:
- CLK  input  1  100 MHz system clock; the block's only clock.
- RST  input  1  synchronous, active-high reset.
- frame_valid  input  1  one-cycle pulse: frame_data holds a new frame.
- frame_data  input  40  raw frame, 5 bytes, first received byte in [39:32].
- cal_req  input  1  one-cycle pulse: start calibration.
- pos_x  output  10  raw X = {frame_data[25:24], frame_data[39:32]}.
- pos_y  output  10  raw Y = {frame_data[9:8], frame_data[23:16]}.
- btn  output  2  buttons = frame_data[1:0].
- vel_x  output  8  signed two's-complement X velocity, range -127..+127.
- vel_y  output  8  signed two's-complement Y velocity, range -127..+127.
- out_valid  output  1  one-cycle pulse: pos/btn/vel updated.
- cal_busy  output  1  high while calibration is in progress.
- center_x  output  10  current X centre.
- center_y  output  10  current Y centre.

Behaviour:
- Reset values (all synchronous on RST=1):
  - pos_x, pos_y, btn, vel_x, vel_y = 0.
  - out_valid = 0, cal_busy = 0.
  - center_x = center_y = 512.
  - Accumulators and frame counter = 0; FSM returns to IDLE.
  - Any in-flight pipeline data is discarded.
- Pipeline:
  - Fully pipelined; accepts frame_valid on any cycle, back-to-back included.
  - Latency 2: frame_valid in cycle N gives out_valid in cycle N+2.
  - Stage 1 (N+1): register pos_x, pos_y, btn; compute d = pos - center as 11-bit signed, range -1023..+1023.
  - Stage 2 (N+2), deadzone, per axis: |d| <= DEADZONE gives 0; d > DEADZONE gives d-DEADZONE; d < -DEADZONE gives d+DEADZONE.
  - Stage 2 (N+2), scaling: arithmetic shift right by SHIFT, then saturate to +127 / -127. The value -128 is never produced.
  - pos_x, pos_y and btn are re-timed so that they update in the same cycle as vel_x and vel_y.
- FSM states:
  - IDLE: on cal_req, go to ACC, clear accumulators and counter, cal_busy <= 1. The frame arriving in the same cycle as cal_req is processed normally and is not accumulated.
  - ACC: each frame_valid adds pos_x/pos_y (stage-1 values) to 10+CAL_LOG2-bit accumulators and increments the counter. After the 2^CAL_LOG2-th sample, go to UPD.
  - UPD: one cycle. center_x/center_y <= accumulator >> CAL_LOG2 (truncating). cal_busy <= 0. Return to IDLE.
- During ACC and UPD:
  - out_valid still pulses.
  - vel_x and vel_y are forced to 0.
  - pos_x, pos_y and btn update normally.
- cal_req while in ACC or UPD is ignored.
- A new center takes effect for the first frame whose stage 1 occurs after UPD.
- Accumulator width guarantees no overflow: max sum 1023*2^CAL_LOG2.

Optional Feature:
- Macro: BTN_FILTER_EN.
- Defined: btn updates only when the same button value has been seen in 2 consecutive frames; otherwise btn holds its previous value. The candidate register resets to 0.
- Undefined: btn follows frame_data[1:0] of every frame with the 2-cycle latency.

Test Plan:
- Reset then frame x=700, y=300, buttons=2'b01 -> after 2 cycles out_valid=1, pos_x=700, pos_y=300, btn=01, vel_x=+43, vel_y=-49.
- Deadzone: x=520, y=500 at centre 512 -> vel_x=0, vel_y=0. Then x=529 -> vel_x=+0 (d=17, 1>>2=0). Then x=532 -> vel_x=+1.
- Calibration: cal_req, then 8 frames with x=496..503 and y=200 constant -> cal_busy high through the 8th frame plus the UPD cycle; center_x=499, center_y=200; vel outputs 0 throughout. Next frame x=499 -> vel_x=0.
- Saturation: after calibrating center_x=100, frame x=1023 -> vel_x=+127. After center_x=1000, frame x=0 -> vel_x=-127.
- Reset mid-calibration: RST asserted after 4 of 8 frames -> cal_busy=0, center=512/512. A subsequent cal_req starts a fresh 8-frame average.
- Back-to-back frame_valid on 3 consecutive cycles -> 3 consecutive out_valid pulses with matching data. With BTN_FILTER_EN defined, button sequence 01,10,10 -> btn=00,00,10.
